// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the nibble ALU sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int NIBBLE_W = 4;

  // Slice select codes; S_ADD and S_XOR share an encoding and differ only by M.
  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_XOR    = 4'b1001;
  localparam logic [3:0] S_PASS_A = 4'b1111;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// rtl/alu_nibble_sequencer_if.sv - request/response handshake bundle for the nibble ALU sequencer
interface alu_nibble_sequencer_if #(
  parameter int WIDTH = 16
) ();

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_s;
  logic             req_m;
  logic             req_cin;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_cout;
  logic             rsp_zero;

  // Requester side: issues operations and consumes results.
  modport master (
    output req_valid, req_s, req_m, req_cin, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_f, rsp_cout, rsp_zero,
    output rsp_ready
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_s, req_m, req_cin, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_f, rsp_cout, rsp_zero,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - drives a 4-bit ALU slice nibble-serially to execute WIDTH-bit operations
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_nibble_sequencer_if.slave bus,
  output logic [NIBBLE_W-1:0] alu_a,
  output logic [NIBBLE_W-1:0] alu_b,
  output logic [3:0]          alu_s,
  output logic                alu_m,
  output logic                alu_cn,
  input  logic [NIBBLE_W-1:0] alu_f,
  input  logic                alu_cn4
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [NIB_W-1:0] nib;
  logic             last_nib;

  assign last_nib = (nib == LAST_NIB);

  // State register; reset aborts any operation in flight without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept, walk the nibbles, hold the result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = RUN;
      RUN:     if (last_nib)      state_nxt = DONE;
      DONE:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then capture one slice result per cycle and chain its carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      nib     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            s_q     <= bus.req_s;
            m_q     <= bus.req_m;
            carry_q <= bus.req_cin;
            nib     <= '0;
          end
        end
        RUN: begin
          res_q[NIBBLE_W*nib +: NIBBLE_W] <= alu_f;
          carry_q                         <= alu_cn4;
          if (!last_nib) nib <= nib + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state only, so handshake inputs never reach handshake outputs combinationally.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_s         = '0;
    alu_m         = 1'b0;
    alu_cn        = 1'b0;
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == DONE);
    bus.rsp_f     = '0;
    bus.rsp_cout  = 1'b0;
    if (state == RUN) begin
      alu_a  = a_q[NIBBLE_W*nib +: NIBBLE_W];
      alu_b  = b_q[NIBBLE_W*nib +: NIBBLE_W];
      alu_s  = s_q;
      alu_m  = m_q;
      alu_cn = carry_q;
    end
    if (state == DONE) begin
      bus.rsp_f    = res_q;
      bus.rsp_cout = carry_q;
    end
    bus.rsp_zero = (bus.rsp_f == '0);
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - directed scoreboard bench for the nibble ALU sequencer
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [15:0] f;
    logic        cout;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb16[$];
  exp_t sb4[$];

  alu_nibble_sequencer_if #(.WIDTH(16)) bus16 ();
  alu_nibble_sequencer_if #(.WIDTH(4))  bus4 ();

  logic [3:0] a16, b16, s16, f16, a4, b4, s4, f4;
  logic       m16, cn16, cn4_16, m4, cn4, cn4_4;

  alu_nibble_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16),
    .alu_a(a16), .alu_b(b16), .alu_s(s16), .alu_m(m16), .alu_cn(cn16),
    .alu_f(f16), .alu_cn4(cn4_16)
  );

  alu_nibble_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .alu_a(a4), .alu_b(b4), .alu_s(s4), .alu_m(m4), .alu_cn(cn4),
    .alu_f(f4), .alu_cn4(cn4_4)
  );

  // Behavioural 4-bit slice: S=1001 adds (M=0) or XORs (M=1), carry from the add either way; S=1111,M=1 passes A.
  function automatic logic [4:0] slice_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {4'b0, cn};
    if (s == S_ADD) return m ? {sum[4], a ^ b} : sum;
    if (s == S_PASS_A && m) return {1'b0, a};
    return 5'b0;
  endfunction

  assign {cn4_16, f16} = slice_fn(a16, b16, s16, m16, cn16);
  assign {cn4_4, f4}   = slice_fn(a4, b4, s4, m4, cn4);

  // Whole-width reference for a 16-bit operation.
  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
    exp_t e;
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    e.f = 16'h0;
    e.cout = 1'b0;
    if (s == S_ADD) begin
      e.f    = m ? (a ^ b) : sum[15:0];
      e.cout = sum[16];
    end else if (s == S_PASS_A && m) begin
      e.f = a;
    end
    e.zero = (e.f == 16'h0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one 16-bit request; returns cycles from accept to rsp_valid and the carry-in seen per nibble.
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin, output int lat, output logic [3:0] cn_seen);
    int n;
    check("issue_req_ready", {31'b0, bus16.req_ready}, 32'd1);
    bus16.req_a = a; bus16.req_b = b; bus16.req_s = s;
    bus16.req_m = m; bus16.req_cin = cin; bus16.req_valid = 1'b1;
    sb16.push_back(model16(a, b, s, m, cin));
    @(posedge clk);
    #1 bus16.req_valid = 1'b0;
    cn_seen = 4'h0;
    n = 0;
    @(negedge clk);
    while (!bus16.rsp_valid && n < 40) begin
      if (n < 4) cn_seen[n] = cn16;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    lat = n;
  endtask

  // Compare the pending response against the scoreboard and complete the handshake.
  task automatic recv16(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, {31'b0, (sb16.size() > 0)}, 32'd1);
    if (sb16.size() > 0) begin
      e = sb16.pop_front();
      check({tag, "_f"},    {16'b0, bus16.rsp_f},    {16'b0, e.f});
      check({tag, "_cout"}, {31'b0, bus16.rsp_cout}, {31'b0, e.cout});
      check({tag, "_zero"}, {31'b0, bus16.rsp_zero}, {31'b0, e.zero});
    end
    bus16.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus16.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, {31'b0, bus16.req_ready}, 32'd1);
    check({tag, "_valid_after"}, {31'b0, bus16.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [3:0] cns;
    exp_t e;

    bus16.req_valid = 1'b0; bus16.req_a = '0; bus16.req_b = '0; bus16.req_s = '0;
    bus16.req_m = 1'b0; bus16.req_cin = 1'b0; bus16.rsp_ready = 1'b0;
    bus4.req_valid = 1'b0; bus4.req_a = '0; bus4.req_b = '0; bus4.req_s = '0;
    bus4.req_m = 1'b0; bus4.req_cin = 1'b0; bus4.rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", {31'b0, bus16.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus16.rsp_valid}, 32'd0);
    check("rst_rsp_f",     {16'b0, bus16.rsp_f},     32'd0);
    check("rst_rsp_cout",  {31'b0, bus16.rsp_cout},  32'd0);
    check("rst_rsp_zero",  {31'b0, bus16.rsp_zero},  32'd1);
    check("rst_alu",       {19'b0, a16, b16, s16, m16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain add with latency
    issue16(16'h1234, 16'h0FCD, S_ADD, 1'b0, 1'b0, lat, cns);
    check("add_latency", lat, 32'd4);
    recv16("add");

    // Carry ripples through every nibble
    issue16(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b0, lat, cns);
    check("carry_latency", lat, 32'd4);
    check("carry_cn_seq", {28'b0, cns}, 32'hE);
    recv16("carry");

    // Logic mode XOR
    issue16(16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0, lat, cns);
    recv16("xor");

    // Logic mode pass-A
    issue16(16'hA5C3, 16'h1111, S_PASS_A, 1'b1, 1'b1, lat, cns);
    recv16("pass_a");

    // Backpressure: hold rsp_ready low while a new request waits
    issue16(16'h8421, 16'h1357, S_ADD, 1'b0, 1'b1, lat, cns);
    e = sb16[0];
    bus16.req_a = 16'h5555; bus16.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, bus16.rsp_valid}, 32'd1);
      check("bp_rsp_f",     {16'b0, bus16.rsp_f},     {16'b0, e.f});
      check("bp_req_ready", {31'b0, bus16.req_ready}, 32'd0);
    end
    bus16.req_valid = 1'b0;
    recv16("bp");

    // Reset mid-RUN at nibble 2
    bus16.req_a = 16'h1234; bus16.req_b = 16'h4321; bus16.req_s = S_ADD;
    bus16.req_m = 1'b0; bus16.req_cin = 1'b0; bus16.req_valid = 1'b1;
    @(posedge clk);
    #1 bus16.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_alu_a_before", {28'b0, a16}, 32'd2);
    rst = 1'b1;
    #1;
    check("mid_req_ready", {31'b0, bus16.req_ready}, 32'd1);
    check("mid_rsp_valid", {31'b0, bus16.rsp_valid}, 32'd0);
    check("mid_alu",       {18'b0, a16, b16, s16, m16, cn16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue16(16'h0F0F, 16'h0101, S_ADD, 1'b0, 1'b0, lat, cns);
    check("post_rst_latency", lat, 32'd4);
    recv16("post_rst");

    // Single-nibble instance
    e.f = 16'h0; e.cout = 1'b1; e.zero = 1'b1;
    sb4.push_back(e);
    bus4.req_a = 4'h7; bus4.req_b = 4'h8; bus4.req_s = S_ADD;
    bus4.req_m = 1'b0; bus4.req_cin = 1'b1; bus4.req_valid = 1'b1;
    @(posedge clk);
    #1 bus4.req_valid = 1'b0;
    @(negedge clk);
    check("w4_valid_early", {31'b0, bus4.rsp_valid}, 32'd0);
    check("w4_alu_cn",      {31'b0, cn4},            32'd1);
    @(posedge clk);
    @(negedge clk);
    check("w4_valid", {31'b0, bus4.rsp_valid}, 32'd1);
    e = sb4.pop_front();
    check("w4_f",    {28'b0, bus4.rsp_f},    {16'b0, e.f});
    check("w4_cout", {31'b0, bus4.rsp_cout}, {31'b0, e.cout});
    check("w4_zero", {31'b0, bus4.rsp_zero}, {31'b0, e.zero});
    bus4.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus4.rsp_ready = 1'b0;
    @(negedge clk);
    check("w4_ready_after", {31'b0, bus4.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
